// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered occupancy count, threshold flags, sticky error flags
// and standard or first-word-fall-through reads. Optional flush port: SYNC_FIFO_FLUSH_EN.
module sync_fifo_flags #(
  parameter int DSIZE      = 8,
  parameter int ASIZE      = 4,
  parameter int AFULL_LVL  = 14,
  parameter int AEMPTY_LVL = 2,
  parameter int FWFT       = 0
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SYNC_FIFO_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rvalid,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             ovf,
  output logic             udf
);

  localparam int             DEPTH    = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_C  = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AFULL_C  = (ASIZE+1)'(AFULL_LVL);
  localparam logic [ASIZE:0] AEMPTY_C = (ASIZE+1)'(AEMPTY_LVL);

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE-1:0] wptr;
  logic [ASIZE-1:0] rptr;
  logic             clr;
  logic             wa;
  logic             ra;
  logic [ASIZE:0]   count_next;

`ifdef SYNC_FIFO_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  // Accepts are gated by the registered flags; reset and flush swallow both requests.
  assign wa = winc & ~wfull  & rst_n & ~clr;
  assign ra = rinc & ~rempty & rst_n & ~clr;

  always_comb begin
    count_next = count;
    if (wa) count_next = count_next + 1'b1;
    if (ra) count_next = count_next - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      wfull         <= 1'b0;
      walmost_full  <= 1'b0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      ovf           <= 1'b0;
      udf           <= 1'b0;
    end else begin
      if (wa) wptr <= wptr + 1'b1;
      if (ra) rptr <= rptr + 1'b1;
      count         <= count_next;
      wfull         <= (count_next == DEPTH_C);
      walmost_full  <= (count_next >= AFULL_C);
      rempty        <= (count_next == '0);
      ralmost_empty <= (count_next <= AEMPTY_C);
      ovf           <= ovf | (winc & wfull);
      udf           <= udf | (rinc & rempty);
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wa) mem[wptr] <= wdata;
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [DSIZE-1:0] rdata_q;
      logic             rvalid_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else if (clr) begin
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= ra;
          if (ra) rdata_q <= mem[rptr];
        end
      end

      assign rdata  = rdata_q;
      assign rvalid = rvalid_q;
    end else begin : g_fwft
      // Head word is shown directly; it is valid whenever the FIFO holds anything.
      assign rdata  = mem[rptr];
      assign rvalid = ~rempty;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Randomised bench for sync_fifo_flags: standard and FWFT instances share the stimulus
// and are compared against a queue-based reference model.
module tb_sync_fifo_flags;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       winc;
  logic [7:0] wdata;
  logic       rinc;

  logic       wfull_s, walmost_full_s, rvalid_s, rempty_s, ralmost_empty_s, ovf_s, udf_s;
  logic [7:0] rdata_s;
  logic [4:0] count_s;
  logic       wfull_f, walmost_full_f, rvalid_f, rempty_f, ralmost_empty_f, ovf_f, udf_f;
  logic [7:0] rdata_f;
  logic [4:0] count_f;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q[$];
  logic       m_ovf, m_udf, m_rvalid;
  logic [7:0] m_rdata;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DSIZE(8), .ASIZE(4), .AFULL_LVL(14), .AEMPTY_LVL(2), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .wfull(wfull_s),
    .walmost_full(walmost_full_s), .rinc(rinc), .rdata(rdata_s), .rvalid(rvalid_s),
    .rempty(rempty_s), .ralmost_empty(ralmost_empty_s), .count(count_s),
    .ovf(ovf_s), .udf(udf_s)
  );

  sync_fifo_flags #(.DSIZE(8), .ASIZE(4), .AFULL_LVL(14), .AEMPTY_LVL(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .wfull(wfull_f),
    .walmost_full(walmost_full_f), .rinc(rinc), .rdata(rdata_f), .rvalid(rvalid_f),
    .rempty(rempty_f), .ralmost_empty(ralmost_empty_f), .count(count_f),
    .ovf(ovf_f), .udf(udf_f)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Reference behaviour at a clock edge, using the occupancy before the edge.
  task automatic model_edge();
    int  n;
    bit  full, empty, wacc, racc;
    n = q.size();
    if (!rst_n) begin
      q.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_rvalid = 1'b0; m_rdata = 8'h00;
      return;
    end
    full  = (n == DEPTH);
    empty = (n == 0);
    wacc  = winc && !full;
    racc  = rinc && !empty;
    if (winc && full)  m_ovf = 1'b1;
    if (rinc && empty) m_udf = 1'b1;
    m_rvalid = racc;
    if (racc) m_rdata = q.pop_front();
    if (wacc) q.push_back(wdata);
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check_val("count",         32'(count_s),         32'(n));
    check_val("wfull",         32'(wfull_s),         32'(n == DEPTH));
    check_val("walmost_full",  32'(walmost_full_s),  32'(n >= 14));
    check_val("rempty",        32'(rempty_s),        32'(n == 0));
    check_val("ralmost_empty", 32'(ralmost_empty_s), 32'(n <= 2));
    check_val("ovf",           32'(ovf_s),           32'(m_ovf));
    check_val("udf",           32'(udf_s),           32'(m_udf));
    check_val("rvalid",        32'(rvalid_s),        32'(m_rvalid));
    check_val("rdata",         32'(rdata_s),         32'(m_rdata));
    check_val("fwft_count",    32'(count_f),         32'(n));
    check_val("fwft_wfull",    32'(wfull_f),         32'(n == DEPTH));
    check_val("fwft_rempty",   32'(rempty_f),        32'(n == 0));
    check_val("fwft_ovf",      32'(ovf_f),           32'(m_ovf));
    check_val("fwft_udf",      32'(udf_f),           32'(m_udf));
    check_val("fwft_rvalid",   32'(rvalid_f),        32'(n != 0));
    if (n != 0) check_val("fwft_rdata", 32'(rdata_f), 32'(q[0]));
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic rn);
    winc = w; wdata = d; rinc = r; rst_n = rn;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int pw, pr;
    winc = 1'b0; wdata = 8'h00; rinc = 1'b0; rst_n = 1'b0;
    m_ovf = 1'b0; m_udf = 1'b0; m_rvalid = 1'b0; m_rdata = 8'h00;

    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);

    // Fill to full, then one rejected write.
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 1);
    step(1, 8'h10, 0, 1);
    // Drain, then one rejected read.
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 1);
    step(0, 8'h00, 1, 1);

    // Steady state at count 8 with simultaneous traffic across two wraps.
    step(0, 8'h00, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 8'(i), 0, 1);
    for (int i = 0; i < 40; i++) step(1, 8'(8 + i), 1, 1);

    // Full plus both requests.
    step(0, 8'h00, 0, 0);
    for (int i = 0; i < 16; i++) step(1, 8'(8'h40 + i), 0, 1);
    step(1, 8'hEE, 1, 1);

    // Empty plus both requests, then read back the word.
    step(0, 8'h00, 0, 0);
    step(1, 8'hA5, 1, 1);
    step(0, 8'h00, 1, 1);
    step(0, 8'h00, 0, 1);

    // Reset at count 9 while writing; only new data afterwards.
    for (int i = 0; i < 9; i++) step(1, 8'(8'h60 + i), 0, 1);
    step(1, 8'h77, 0, 0);
    step(1, 8'h3C, 0, 1);
    step(0, 8'h00, 1, 1);
    step(0, 8'h00, 0, 1);

    // Random traffic with drifting write/read bias to reach both ends.
    pw = 50; pr = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        pw = $urandom_range(10, 90);
        pr = $urandom_range(10, 90);
      end
      step(($urandom % 100) < pw, 8'($urandom), ($urandom % 100) < pr,
           ($urandom % 200) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
